// File: rtl/idli_pkg.sv
// idli_pkg: shared predicate-register and predicate-compare types.
package idli_pkg;
  localparam int PCMP_DATA_W   = 16;
  localparam int PCMP_NIBBLE_W = 4;
  localparam int PCMP_BEATS    = PCMP_DATA_W / PCMP_NIBBLE_W;
  typedef enum logic [1:0] {P0, P1, P2, P3} preg_t;
  typedef enum logic [1:0] {PCMP_EQ, PCMP_LTU, PCMP_LT, PCMP_TST} pcmp_op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} pcmp_state_t;
  function automatic logic pcmp_sel(input pcmp_op_t op, input logic eq, borrow, any, sa, sb);
    return op == PCMP_EQ  ? eq :
           op == PCMP_LTU ? borrow :
           op == PCMP_LT  ? ((sa != sb) ? sa : borrow) : any;
  endfunction
endpackage

// File: rtl/idli_pcmp_beat_m.sv
// idli_pcmp_beat_m: one nibble of the serial compare (equality, borrow chain, AND-test, sign bits).
module idli_pcmp_beat_m #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         eq,
  output logic         bout,
  output logic         any,
  output logic         msb_a,
  output logic         msb_b
);
  assign eq    = a == b;
  // a - b - bin underflows exactly when a < b + bin
  assign bout  = (a < b) || ((a == b) && bin);
  assign any   = |(a & b);
  assign msb_a = a[W-1];
  assign msb_b = b[W-1];
endmodule

// File: rtl/idli_pcmp_m.sv
// idli_pcmp_m: nibble-serial predicate compare feeding the predicate register file Q port.
// Optional IDLI_PCMP_INV_EN adds i_pcmp_inv to invert the written predicate.
module idli_pcmp_m
  import idli_pkg::*;
#(
  parameter int DATA_W   = PCMP_DATA_W,
  parameter int NIBBLE_W = PCMP_NIBBLE_W
) (
  input  logic                i_pcmp_gck,
  input  logic                i_pcmp_rst_n,
  input  logic                i_pcmp_start,
  input  pcmp_op_t            i_pcmp_op,
  input  preg_t               i_pcmp_q,
  input  logic                i_pcmp_vld,
  input  logic [NIBBLE_W-1:0] i_pcmp_a,
  input  logic [NIBBLE_W-1:0] i_pcmp_b,
`ifdef IDLI_PCMP_INV_EN
  input  logic                i_pcmp_inv,
`endif
  output logic                o_pcmp_busy,
  output preg_t               o_pcmp_q,
  output logic                o_pcmp_q_wr_en,
  output logic                o_pcmp_q_data
);
  localparam int BEATS = DATA_W / NIBBLE_W;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  pcmp_state_t state, state_nxt;
  logic [CW-1:0] ctr;
  pcmp_op_t op_r, op_eff;
  preg_t q_r, q_eff;
  logic eq_r, borrow_r, any_r;
  logic idle, take, last, first, eq_in, borrow_in, any_in;
  logic b_eq, b_bout, b_any, sa, sb, res, inv_eff;
  assign idle      = state == IDLE;
  assign take      = i_pcmp_vld && (idle ? i_pcmp_start : state == BUSY);
  assign last      = ctr == CW'(BEATS - 1);
  // ctr is zero at the first beat of every op, so it doubles as the accumulator seed select
  assign first     = ctr == '0;
  assign eq_in     = first | eq_r;
  assign borrow_in = !first & borrow_r;
  assign any_in    = !first & any_r;
  assign op_eff    = idle ? i_pcmp_op : op_r;
  assign q_eff     = idle ? i_pcmp_q : q_r;
  idli_pcmp_beat_m #(.W(NIBBLE_W)) u_beat (
    .a     (i_pcmp_a),
    .b     (i_pcmp_b),
    .bin   (borrow_in),
    .eq    (b_eq),
    .bout  (b_bout),
    .any   (b_any),
    .msb_a (sa),
    .msb_b (sb)
  );
`ifdef IDLI_PCMP_INV_EN
  logic inv_r;
  always_ff @(posedge i_pcmp_gck or negedge i_pcmp_rst_n)
    if (!i_pcmp_rst_n) inv_r <= 1'b0;
    else if (idle && i_pcmp_start) inv_r <= i_pcmp_inv;
  assign inv_eff = idle ? i_pcmp_inv : inv_r;
`else
  assign inv_eff = 1'b0;
`endif
  assign res = pcmp_sel(op_eff, eq_in & b_eq, b_bout, any_in | b_any, sa, sb) ^ inv_eff;
  always_comb begin
    state_nxt      = state == DONE   ? IDLE :
                     take && last    ? DONE :
                     idle && i_pcmp_start ? BUSY : state;
    o_pcmp_busy    = !idle;
    o_pcmp_q_wr_en = state == DONE && o_pcmp_q != P3;
  end
  always_ff @(posedge i_pcmp_gck or negedge i_pcmp_rst_n)
    if (!i_pcmp_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge i_pcmp_gck or negedge i_pcmp_rst_n)
    if (!i_pcmp_rst_n) begin
      ctr           <= '0;
      op_r          <= PCMP_EQ;
      q_r           <= P0;
      eq_r          <= 1'b0;
      borrow_r      <= 1'b0;
      any_r         <= 1'b0;
      o_pcmp_q      <= P0;
      o_pcmp_q_data <= 1'b0;
    end else begin
      if (idle && i_pcmp_start) begin
        op_r <= i_pcmp_op;
        q_r  <= i_pcmp_q;
      end
      if (take) begin
        ctr      <= last ? '0 : ctr + 1'b1;
        eq_r     <= eq_in & b_eq;
        borrow_r <= b_bout;
        any_r    <= any_in | b_any;
      end
      if (take && last) begin
        o_pcmp_q      <= q_eff;
        o_pcmp_q_data <= res;
      end
    end
endmodule

// File: tb/tb_idli_pcmp_m.sv
// tb_idli_pcmp_m: directed table plus randomized ops against a whole-operand reference model.
module tb_idli_pcmp_m;
  import idli_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, vld = 1'b0, inv_i = 1'b0;
  pcmp_op_t op_i = PCMP_EQ;
  preg_t q_i = P0, q_o;
  logic [3:0] a_i = '0, b_i = '0;
  logic busy, wr_en, data;
  int cyc = 0, strobe_cnt = 0, n_chk = 0, n_fail = 0;

  idli_pcmp_m dut (
    .i_pcmp_gck     (clk),
    .i_pcmp_rst_n   (rst_n),
    .i_pcmp_start   (start),
    .i_pcmp_op      (op_i),
    .i_pcmp_q       (q_i),
    .i_pcmp_vld     (vld),
    .i_pcmp_a       (a_i),
    .i_pcmp_b       (b_i),
`ifdef IDLI_PCMP_INV_EN
    .i_pcmp_inv     (inv_i),
`endif
    .o_pcmp_busy    (busy),
    .o_pcmp_q       (q_o),
    .o_pcmp_q_wr_en (wr_en),
    .o_pcmp_q_data  (data)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en) strobe_cnt <= strobe_cnt + 1;

  typedef struct {
    pcmp_op_t    op;
    preg_t       q;
    logic [15:0] a;
    logic [15:0] b;
    int          stall;
    bit          spur;
    logic        exp;
  } vec_t;

  function automatic logic model(input pcmp_op_t op, input logic [15:0] a, b, input logic inv);
    logic r;
    r = op == PCMP_EQ  ? (a == b) :
        op == PCMP_LTU ? (a < b) :
        op == PCMP_LT  ? ($signed(a) < $signed(b)) : (|(a & b));
`ifdef IDLI_PCMP_INV_EN
    return r ^ inv;
`else
    return r ^ (inv & 1'b0);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input pcmp_op_t op, input preg_t q, input logic [15:0] a, b,
                       input int stall, input bit spur, input logic inv,
                       output bit got, output logic d, output preg_t gq, output int lat,
                       output logic busy_mid);
    int c0, k;
    c0 = cyc;
    start = 1'b1; op_i = op; q_i = q; inv_i = inv; vld = 1'b1; a_i = a[3:0]; b_i = b[3:0];
    step();
    busy_mid = busy;
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (i == 2) begin
        vld = 1'b0;
        repeat (stall) step();
      end
      vld = 1'b1; a_i = a[i*4 +: 4]; b_i = b[i*4 +: 4];
      start = spur && i == 2;
      op_i  = (spur && i == 2) ? PCMP_TST : op;
      q_i   = (spur && i == 2) ? P2 : q;
      inv_i = (spur && i == 2) ? ~inv : inv;
      step();
      start = 1'b0;
    end
    vld = 1'b0;
    k = 0;
    while (!wr_en && k < 8) begin
      step();
      k++;
    end
    got = wr_en; d = data; gq = q_o; lat = cyc - c0;
  endtask

  task automatic run_check(input string nm, input pcmp_op_t op, input preg_t q,
                           input logic [15:0] a, b, input int stall, input bit spur,
                           input logic inv, input logic exp);
    bit got;
    logic d, bm;
    preg_t gq;
    int lat, s0;
    s0 = strobe_cnt;
    do_op(op, q, a, b, stall, spur, inv, got, d, gq, lat, bm);
    chk({nm, " busy"}, bm, 1);
    chk({nm, " strobe"}, got, q != P3);
    if (q != P3) begin
      chk({nm, " data"}, d, exp);
      chk({nm, " q"}, gq, q);
      chk({nm, " latency"}, lat, 4 + stall);
    end
    step();
    chk({nm, " wr_en after"}, wr_en, 0);
    chk({nm, " idle after"}, busy, 0);
    chk({nm, " strobe count"}, strobe_cnt - s0, (q != P3) ? 1 : 0);
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{PCMP_EQ,  P1, 16'h1234, 16'h1234, 0, 0, 1'b1};
    vt[1] = '{PCMP_LTU, P0, 16'hFFFF, 16'h0001, 0, 0, 1'b0};
    vt[2] = '{PCMP_LT,  P0, 16'hFFFF, 16'h0001, 0, 0, 1'b1};
    vt[3] = '{PCMP_LT,  P1, 16'h7FFF, 16'h8000, 0, 0, 1'b0};
    vt[4] = '{PCMP_TST, P2, 16'h00F0, 16'h0F10, 0, 0, 1'b1};
    vt[5] = '{PCMP_TST, P2, 16'h00F0, 16'h0F0F, 0, 0, 1'b0};
    vt[6] = '{PCMP_EQ,  P1, 16'h1234, 16'h1234, 3, 0, 1'b1};
    vt[7] = '{PCMP_EQ,  P1, 16'h1111, 16'h1110, 0, 1, 1'b0};
    vt[8] = '{PCMP_EQ,  P3, 16'h0000, 16'h0000, 0, 0, 1'b1};
    vt[9] = '{PCMP_LTU, P2, 16'h0001, 16'hFFFF, 0, 0, 1'b1};

    step();
    step();
    chk("reset busy", busy, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset q", q_o, 0);
    chk("reset data", data, 0);
    rst_n = 1'b1;
    vld = 1'b1;
    step();
    step();
    chk("vld without start", busy, 0);
    vld = 1'b0;
    step();

    foreach (vt[i])
      run_check($sformatf("vec%0d", i), vt[i].op, vt[i].q, vt[i].a, vt[i].b,
                vt[i].stall, vt[i].spur, 1'b0, vt[i].exp);

    begin : mid_reset
      int s0;
      s0 = strobe_cnt;
      start = 1'b1; op_i = PCMP_EQ; q_i = P1; vld = 1'b1; a_i = 4'h4; b_i = 4'h4;
      step();
      start = 1'b0;
      step();
      step();
      vld = 1'b0;
      rst_n = 1'b0;
      step();
      chk("mid reset busy", busy, 0);
      chk("mid reset wr_en", wr_en, 0);
      step();
      rst_n = 1'b1;
      repeat (6) step();
      chk("mid reset no strobe", strobe_cnt - s0, 0);
      chk("mid reset idle", busy, 0);
      run_check("post reset", PCMP_LT, P2, 16'h8000, 16'h0000, 0, 0, 1'b0, 1'b1);
    end

`ifdef IDLI_PCMP_INV_EN
    run_check("inv eq", PCMP_EQ, P1, 16'h0000, 16'h0000, 0, 0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      pcmp_op_t op;
      preg_t q;
      logic [15:0] a, b;
      logic inv;
      op  = pcmp_op_t'($urandom_range(0, 3));
      q   = preg_t'($urandom_range(0, 3));
      a   = 16'($urandom);
      b   = $urandom_range(0, 3) == 0 ? a : ($urandom_range(0, 1) == 1 ? a ^ 16'(1 << $urandom_range(0, 15)) : 16'($urandom));
      inv = 1'($urandom_range(0, 1));
`ifndef IDLI_PCMP_INV_EN
      inv = 1'b0;
`endif
      run_check($sformatf("rand%0d", i), op, q, a, b, int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), inv, model(op, a, b, inv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
